// File: rtl/serial_adder_ctrl_if.sv
// Handshake, operand/result and full-adder cell signals of the bit-serial adder controller.
// The slave modport is the controller side; the master modport is the requester / adder-cell side.
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             ci_in;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             co;
    logic             fa_a;
    logic             fa_b;
    logic             fa_ci;
    logic             fa_s;
    logic             fa_co;

    modport slave (
        input  start, a_in, b_in, ci_in, fa_s, fa_co,
        output ready, busy, done, sum, co, fa_a, fa_b, fa_ci
    );

    modport master (
        output start, a_in, b_in, ci_in, fa_s, fa_co,
        input  ready, busy, done, sum, co, fa_a, fa_b, fa_ci
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder controller: feeds one external full-adder cell LSB first
// and assembles the sum and final carry behind a start/busy/done handshake.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_adder_ctrl_if.slave   bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] areg_q, areg_d;
    logic [WIDTH-1:0] breg_q, breg_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             creg_q, creg_d;
    logic             co_q, co_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sreg_shift;
    logic             last_bit;
    logic             accept;

    // Returned sum bit enters at the MSB; a 1-bit build has nothing to shift down.
    generate
        if (WIDTH == 1) begin : g_w1
            assign sreg_shift = bus.fa_s;
        end else begin : g_wn
            assign sreg_shift = {bus.fa_s, sreg_q[WIDTH-1:1]};
        end
    endgenerate

    assign last_bit = (cnt_q == CW'(WIDTH - 1));
    assign accept   = bus.start && (state_q != ST_SHIFT);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.start) state_d = ST_SHIFT;
            ST_SHIFT: if (last_bit)  state_d = ST_DONE;
            ST_DONE:  state_d = bus.start ? ST_SHIFT : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            areg_q <= '0;
            breg_q <= '0;
            sreg_q <= '0;
            sum_q  <= '0;
            creg_q <= 1'b0;
            co_q   <= 1'b0;
            cnt_q  <= '0;
        end else begin
            areg_q <= areg_d;
            breg_q <= breg_d;
            sreg_q <= sreg_d;
            sum_q  <= sum_d;
            creg_q <= creg_d;
            co_q   <= co_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        areg_d = areg_q;
        breg_d = breg_q;
        sreg_d = sreg_q;
        sum_d  = sum_q;
        creg_d = creg_q;
        co_d   = co_q;
        cnt_d  = cnt_q;
        if (accept) begin
            areg_d = bus.a_in;
            breg_d = bus.b_in;
            creg_d = bus.ci_in;
            sreg_d = '0;
            cnt_d  = '0;
        end else if (state_q == ST_SHIFT) begin
            areg_d = areg_q >> 1;
            breg_d = breg_q >> 1;
            sreg_d = sreg_shift;
            creg_d = bus.fa_co;
            cnt_d  = cnt_q + 1'b1;
            if (last_bit) begin
                sum_d = sreg_shift;
                co_d  = bus.fa_co;
            end
        end
    end

    // Outputs: cell inputs come straight from registers, gated to zero outside SHIFT
    always_comb begin
        bus.ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
        bus.busy  = (state_q == ST_SHIFT);
        bus.done  = (state_q == ST_DONE);
        bus.sum   = sum_q;
        bus.co    = co_q;
        bus.fa_a  = 1'b0;
        bus.fa_b  = 1'b0;
        bus.fa_ci = 1'b0;
        if (state_q == ST_SHIFT) begin
            bus.fa_a  = areg_q[0];
            bus.fa_b  = breg_q[0];
            bus.fa_ci = creg_q;
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: WIDTH=8 and WIDTH=1 instances, each driving an ideal full adder.
module tb_serial_adder_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   dcount8 = 0;
    int   dcount1 = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl_if #(.WIDTH(8)) bus8 ();
    serial_adder_ctrl_if #(.WIDTH(1)) bus1 ();

    serial_adder_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    serial_adder_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    // Ideal full-adder cells on the return path
    assign bus8.fa_s  = bus8.fa_a ^ bus8.fa_b ^ bus8.fa_ci;
    assign bus8.fa_co = (bus8.fa_a & bus8.fa_b) | (bus8.fa_a & bus8.fa_ci) | (bus8.fa_b & bus8.fa_ci);
    assign bus1.fa_s  = bus1.fa_a ^ bus1.fa_b ^ bus1.fa_ci;
    assign bus1.fa_co = (bus1.fa_a & bus1.fa_b) | (bus1.fa_a & bus1.fa_ci) | (bus1.fa_b & bus1.fa_ci);

    // Cycles with done high, tallied away from the negedge where the bench reads them
    always @(posedge clk) begin
        if (bus8.done) dcount8 <= dcount8 + 1;
        if (bus1.done) dcount1 <= dcount1 + 1;
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic [7:0] exp_sum;
        logic       exp_co;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Waits (at negedges) until done is seen; lat counts clock edges since start was raised
    task automatic wait_done8(output int lat);
        lat = 1;
        while (!bus8.done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!bus8.done) begin
            checks++;
            failures++;
            $display("FAIL done8_timeout: got=no_done expected=done");
        end
    endtask

    task automatic do_add8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                           output logic [8:0] res, output int lat);
        @(negedge clk);
        bus8.a_in  = a;
        bus8.b_in  = b;
        bus8.ci_in = ci;
        bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        wait_done8(lat);
        res = {bus8.co, bus8.sum};
    endtask

    initial begin
        vec_t       vecs[8];
        logic [8:0] res;
        logic [8:0] model;
        int         lat;
        int         d0;

        vecs[0] = '{8'h3C, 8'h05, 1'b0, 8'h41, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0};
        vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[6] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
        vecs[7] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};

        bus8.start = 1'b0; bus8.a_in = '0; bus8.b_in = '0; bus8.ci_in = 1'b0;
        bus1.start = 1'b0; bus1.a_in = '0; bus1.b_in = '0; bus1.ci_in = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_ready", bus8.ready, 1);
        check("rst_busy", bus8.busy, 0);
        check("rst_done", bus8.done, 0);
        check("rst_sumco", {bus8.co, bus8.sum}, 0);
        check("rst_fa", {bus8.fa_a, bus8.fa_b, bus8.fa_ci}, 0);
        check("rst_w1_ready", bus1.ready, 1);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            do_add8(vecs[i].a, vecs[i].b, vecs[i].ci, res, lat);
            check($sformatf("vec%0d_sumco", i), res, {vecs[i].exp_co, vecs[i].exp_sum});
            check($sformatf("vec%0d_latency", i), lat, 9);
            check($sformatf("vec%0d_ready", i), bus8.ready, 1);
            @(negedge clk);
            check($sformatf("vec%0d_done_pulse", i), bus8.done, 0);
            check($sformatf("vec%0d_held", i), {bus8.co, bus8.sum}, {vecs[i].exp_co, vecs[i].exp_sum});
        end

        // start during SHIFT must be ignored
        d0 = dcount8;
        @(negedge clk);
        bus8.a_in = 8'h3C; bus8.b_in = 8'h05; bus8.ci_in = 1'b0; bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        check("shift_fa_bits", {bus8.fa_a, bus8.fa_b, bus8.fa_ci}, 3'b010);
        check("shift_busy", {bus8.busy, bus8.ready}, 2'b10);
        repeat (2) @(negedge clk);
        bus8.a_in = 8'hFF; bus8.b_in = 8'hFF; bus8.ci_in = 1'b1; bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        lat = 4;
        while (!bus8.done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("ign_latency", lat, 9);
        check("ign_sumco", {bus8.co, bus8.sum}, 9'h041);
        repeat (12) @(negedge clk);
        check("ign_one_done", dcount8 - d0, 1);

        // back-to-back: start held in the DONE cycle
        do_add8(8'h01, 8'h02, 1'b0, res, lat);
        check("b2b_first", res, 9'h003);
        bus8.a_in = 8'h10; bus8.b_in = 8'h20; bus8.ci_in = 1'b0; bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        check("b2b_no_idle", {bus8.busy, bus8.ready}, 2'b10);
        wait_done8(lat);
        check("b2b_latency", lat, 9);
        check("b2b_sumco", {bus8.co, bus8.sum}, 9'h030);

        // reset mid-SHIFT aborts with no done
        do_add8(8'h3C, 8'h05, 1'b0, res, lat);
        @(negedge clk);
        bus8.a_in = 8'hC3; bus8.b_in = 8'h77; bus8.ci_in = 1'b1; bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (3) @(negedge clk);
        d0 = dcount8;
        rst_n = 1'b0;
        #1;
        check("abort_sumco", {bus8.co, bus8.sum}, 0);
        check("abort_flags", {bus8.ready, bus8.busy, bus8.done}, 3'b100);
        check("abort_fa", {bus8.fa_a, bus8.fa_b, bus8.fa_ci}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("abort_no_done", dcount8 - d0, 0);
        do_add8(8'h01, 8'h01, 1'b0, res, lat);
        check("abort_after_sumco", res, 9'h002);

        // random operands against plain integer addition
        for (int i = 0; i < 40; i++) begin
            logic [7:0] ra, rb;
            logic       rc;
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom_range(1, 0));
            model = {1'b0, ra} + {1'b0, rb} + {8'b0, rc};
            do_add8(ra, rb, rc, res, lat);
            check($sformatf("rnd%0d_%0h_%0h_%0h", i, ra, rb, rc), res, model);
            check($sformatf("rnd%0d_latency", i), lat, 9);
        end

        // WIDTH=1 build: 1+1+1
        d0 = dcount1;
        @(negedge clk);
        bus1.a_in = 1'b1; bus1.b_in = 1'b1; bus1.ci_in = 1'b1; bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        check("w1_busy", bus1.busy, 1);
        lat = 1;
        while (!bus1.done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("w1_latency", lat, 2);
        check("w1_sumco", {bus1.co, bus1.sum}, 2'b11);
        repeat (4) @(negedge clk);
        check("w1_one_done", dcount1 - d0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got=timeout expected=finish");
        $fatal(1, "timeout");
    end
endmodule
